// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared widths and FSM state encodings for the I2C bus arbiter.
package i2c_bus_arbiter_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and I2C-master-side signals of the bus arbiter.
interface i2c_bus_arbiter_if import i2c_bus_arbiter_pkg::*; #(parameter int NREQ = 4) ();
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   nack;
  logic                   timeout;
  logic                   m_start;
  logic                   m_abort;
  logic                   m_rw;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic                   m_busy;
  logic                   m_done;
  logic                   m_nack;
  logic [DATA_W-1:0]      m_rdata;

  modport master (
    input  req, req_rw, req_addr, req_wdata, m_busy, m_done, m_nack, m_rdata,
    output gnt, done, rdata, nack, timeout, m_start, m_abort, m_rw, m_addr, m_wdata
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, rdata, nack, timeout, m_start, m_abort, m_rw, m_addr, m_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, one-hot.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Arbitrates NREQ requesters onto one I2C master: grant, issue, wait with timeout, respond.
//   state    | meaning
//   IDLE     | pick round-robin winner, latch its command
//   ISSUE    | wait for master idle, then pulse m_start
//   WAIT     | count cycles until m_done or timeout abort
//   RESP     | one-cycle done pulse, grant released
module i2c_bus_arbiter import i2c_bus_arbiter_pkg::*; #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             clk,
  input logic             rst,
  i2c_bus_arbiter_if.master bus
);
  localparam int             PW       = $clog2(NREQ);
  localparam int             CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [PW-1:0]     ptr, win_idx, ptr_next;
  logic [NREQ-1:0]   win_oh, gnt_q, done_q;
  logic [CW-1:0]     cnt;
  logic              m_start_q, m_abort_q, m_rw_q, nack_q, timeout_q, sel_rw;
  logic [ADDR_W-1:0] m_addr_q, sel_addr;
  logic [DATA_W-1:0] m_wdata_q, rdata_q, sel_wdata;

  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req), .ptr(ptr), .win(win_oh));

  always_comb begin
    win_idx   = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_idx   = PW'(i);
        sel_rw    = bus.req_rw[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      cnt       <= '0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      done_q    <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_q     <= win_oh;
            m_rw_q    <= sel_rw;
            m_addr_q  <= sel_addr;
            m_wdata_q <= sel_wdata;
            ptr       <= ptr_next;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.m_busy) begin
            m_start_q <= 1'b1;
            cnt       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
          // m_done takes priority over a timeout landing in the same cycle
          if (bus.m_done) begin
            rdata_q   <= m_rw_q ? bus.m_rdata : '0;
            nack_q    <= bus.m_nack;
            timeout_q <= 1'b0;
            done_q    <= gnt_q;
            state     <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            m_abort_q <= 1'b1;
            timeout_q <= 1'b1;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
            done_q    <= gnt_q;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          gnt_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.nack    = nack_q;
  assign bus.timeout = timeout_q;
  assign bus.m_start = m_start_q;
  assign bus.m_abort = m_abort_q;
  assign bus.m_rw    = m_rw_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: TIMEOUT_CYC, 1024, cycles in WAIT before abort (16..65535).
REQ-003 Port: clk  in  1  clock; all logic on posedge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req  in  NREQ  per-requester transaction request, level, held until that requester's done.
REQ-006 Port: req_rw  in  NREQ  per-requester direction, 1 read / 0 write.
REQ-007 Port: req_addr  in  NREQ*7  per-requester 7-bit slave address, requester i at bits [7i+6:7i].
REQ-008 Port: req_wdata  in  NREQ*8  per-requester write byte, requester i at bits [8i+7:8i].
REQ-009 Port: gnt  out  NREQ  one-hot grant, held from ISSUE through RESP.
REQ-010 Port: done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 Port: rdata  out  8  read byte, valid during the done pulse.
REQ-012 Port: nack / timeout  out  1 each  status flags, valid during the done pulse.
REQ-013 Port: m_start, m_abort  out  1 each  single-cycle command pulses to the I2C master.
REQ-014 Port: m_rw  out 1 / m_addr  out 7 / m_wdata  out 8  latched command fields, stable from ISSUE through RESP.
REQ-015 Port: m_busy, m_done, m_nack  in  1 each; m_rdata  in  8  master status; m_done is a one-cycle pulse.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req bit is set, select a winner by round-robin, latch its rw/addr/wdata, set gnt, and go to ISSUE next cycle.
REQ-018 Round-robin: search starts at (last_winner+1) mod NREQ; last_winner updates on every grant; after reset the search starts at index 0.
REQ-019 ISSUE: while m_busy=1, hold. On the first cycle with m_busy=0, pulse m_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-020 WAIT: the counter increments each cycle. On m_done, capture m_rdata and m_nack and go to RESP.
REQ-021 WAIT: if the counter reaches TIMEOUT_CYC-1 without m_done, pulse m_abort for one cycle, set timeout=1 and rdata=0x00, and go to RESP.
REQ-022 WAIT: if m_done and timeout occur in the same cycle, m_done wins, and m_abort and timeout stay 0.
REQ-023 RESP: one cycle; done[winner]=1 with rdata/nack/timeout valid; gnt clears at the end of RESP; next state is IDLE.
REQ-024 Minimum arbitration gap: one IDLE cycle between consecutive transactions.
REQ-025 A req deasserted after grant is ignored: the transaction completes and done is still pulsed.
REQ-026 req changes on non-granted lines during ISSUE/WAIT/RESP have no effect until IDLE.
REQ-027 m_done in IDLE, ISSUE or RESP is ignored.
REQ-028 Write transactions return rdata=0x00.
REQ-029 Counter width is clog2(TIMEOUT_CYC); the counter does not wrap before the timeout fires.

Reset
REQ-030 rst sets state=IDLE and the round-robin pointer to 0.
REQ-031 rst clears gnt, done, m_start, m_abort, nack, timeout, rdata, m_rw, m_addr, m_wdata, and the counter.
REQ-032 rst during ISSUE/WAIT/RESP drops the transaction silently: no done pulse and no m_abort pulse.

Structure
REQ-033 A shared package holds the state enum, the I2C 7-bit address width constant, and the data width (8).
REQ-034 One sub-module, rr_arbiter, takes (req, pointer) and outputs a one-hot winner; it is purely combinational.
REQ-035 The FSM, latches and timeout counter live in i2c_bus_arbiter.

Verification
REQ-036 Single request: req=0001, rw=0, addr=0x01, wdata=0xA5; m_done after 20 cycles.
- Required: gnt=0001, m_addr=0x01, m_wdata=0xA5, one m_start pulse.
- Required: done=0001 one cycle after m_done, nack=0, timeout=0.
REQ-037 Fairness: req=1111 held continuously, master completes each transaction.
- Required: grant order 0,1,2,3,0; exactly one done per grant.
REQ-038 Read with NACK: req=0100, rw=1; master returns m_rdata=0x3C, m_nack=1.
- Required: done=0100, rdata=0x3C, nack=1.
REQ-039 Timeout: TIMEOUT_CYC=16, master never asserts m_done.
- Required: m_abort pulses 16 cycles after m_start, then done with timeout=1, rdata=0x00.
- Required: m_done and timeout in the same cycle gives timeout=0.
REQ-040 Busy hold and reset abort:
- m_busy=1 for 10 cycles after grant: m_start fires on the first cycle m_busy=0.
- rst asserted in WAIT: next cycle all outputs are 0, no done pulse, no m_abort pulse; the next grant goes to requester 0.
